// File: rtl/lsx_cnt_pkg.sv
// Shared types and next-state helpers for the lsx up/down counter family.
// All arithmetic runs in 33 bits so any WIDTH up to 32 with MOD up to 2**WIDTH fits.
package lsx_cnt_pkg;

  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  localparam int unsigned CNT_CALC_W = 33;

  typedef logic [CNT_CALC_W-1:0] cnt_val_t;

  typedef struct packed {
    cnt_val_t nxt;
    logic     term;
  } cnt_step_t;

  // Terminal state depends on direction: top of range counting up, zero counting down.
  function automatic logic cnt_is_term(input cnt_val_t q, input logic up, input cnt_val_t mod);
    cnt_val_t last;
    last = mod - cnt_val_t'(1);
    return up ? (q == last) : (q == '0);
  endfunction

  function automatic cnt_step_t cnt_next(input cnt_val_t q, input logic up,
                                         input cnt_val_t mod, input logic sat);
    cnt_step_t s;
    cnt_val_t  last;
    last   = mod - cnt_val_t'(1);
    s.term = cnt_is_term(q, up, mod);
    if (up) begin
      if (s.term) s.nxt = (sat == CNT_SAT) ? last : '0;
      else        s.nxt = q + cnt_val_t'(1);
    end else begin
      if (s.term) s.nxt = (sat == CNT_SAT) ? '0 : last;
      else        s.nxt = q - cnt_val_t'(1);
    end
    return s;
  endfunction

  // Out-of-range load values pin to the top legal state.
  function automatic cnt_val_t cnt_clamp(input cnt_val_t d, input cnt_val_t mod);
    return (d < mod) ? d : (mod - cnt_val_t'(1));
  endfunction

endpackage

// File: rtl/lsx_cnt_tc.sv
// Combinational terminal-count detect and ENT-gated ripple carry/borrow.
// Kept separate so cascade wrappers can reuse it without the count register.
module lsx_cnt_tc
  import lsx_cnt_pkg::*;
#(
  parameter int unsigned       WIDTH = 4,
  parameter longint unsigned   MOD   = 16
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_up,
  input  logic             i_ent,
  output logic             o_term,
  output logic             o_rco
);

  localparam cnt_val_t LP_MOD = cnt_val_t'(MOD);

  logic w_term;

  assign w_term = cnt_is_term(cnt_val_t'(i_q), i_up, LP_MOD);
  assign o_term = w_term;
  // Independent of ENP and LOAD_n so a cascade sees carry as soon as Q reaches terminal.
  assign o_rco  = i_ent & w_term;

endmodule

// File: rtl/lsx_updown_counter.sv
// Parametrised presettable up/down counter with wrap/saturate mode, '161-style
// ENP/ENT cascading, combinational RCO and a registered terminal-event pulse.
module lsx_updown_counter
  import lsx_cnt_pkg::*;
#(
  parameter int unsigned     WIDTH    = 4,
  parameter longint unsigned MOD      = 16,
  parameter int unsigned     SATURATE = 0
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_n,
  input  logic             ENP,
  input  logic             ENT,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC_PULSE
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("lsx_updown_counter: WIDTH must be in 2..32");
  end
  if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("lsx_updown_counter: MOD must satisfy 2 <= MOD <= 2**WIDTH");
  end

  localparam cnt_val_t LP_MOD  = cnt_val_t'(MOD);
  localparam logic     LP_MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

  logic [WIDTH-1:0] r_q;
  logic             r_tc;

  cnt_step_t w_step;
  cnt_val_t  w_load;
  logic      w_term;
  logic      w_rco;
  logic      w_count;
  logic      w_unused;

  lsx_cnt_tc #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_tc (
    .i_q    (r_q),
    .i_up   (UP),
    .i_ent  (ENT),
    .o_term (w_term),
    .o_rco  (w_rco)
  );

  assign w_step  = cnt_next(cnt_val_t'(r_q), UP, LP_MOD, LP_MODE);
  assign w_load  = cnt_clamp(cnt_val_t'(D), LP_MOD);
  assign w_count = ENP & ENT;

  // Results are always below MOD, so the bits above WIDTH are structurally zero.
  assign w_unused = ^{w_step.nxt[CNT_CALC_W-1:WIDTH], w_step.term, w_load[CNT_CALC_W-1:WIDTH]};

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q  <= '0;
      r_tc <= 1'b0;
    end else if (!LOAD_n) begin
      r_q  <= w_load[WIDTH-1:0];
      r_tc <= 1'b0;
    end else if (w_count) begin
      r_q  <= w_step.nxt[WIDTH-1:0];
      // Fires on every terminal step, including repeated saturated holds.
      r_tc <= w_term;
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign Q        = r_q;
  assign RCO      = w_rco;
  assign TC_PULSE = r_tc;

endmodule

// File: tb/tb_lsx_updown_counter.sv
// Bench for lsx_updown_counter: wrap and saturate instances (WIDTH=4, MOD=10) on shared inputs.
module tb_lsx_updown_counter;

  logic       CLK = 1'b0;
  logic       CLR;
  logic [3:0] D;
  logic       LOAD_n, ENP, ENT, UP;
  logic [3:0] q_w, q_s;
  logic       rco_w, rco_s, tc_w, tc_s;

  lsx_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(0)) dut_w (
    .CLK(CLK), .CLR(CLR), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT), .UP(UP),
    .Q(q_w), .RCO(rco_w), .TC_PULSE(tc_w)
  );

  lsx_updown_counter #(.WIDTH(4), .MOD(10), .SATURATE(1)) dut_s (
    .CLK(CLK), .CLR(CLR), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT), .UP(UP),
    .Q(q_s), .RCO(rco_s), .TC_PULSE(tc_s)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference: index 0 wraps (modular arithmetic), index 1 saturates (min/max).
  int mq[2];
  int mtc[2];

  typedef struct {
    bit       ln;
    bit [3:0] d;
    bit       p, t, u;
    int       eq;
    bit       etc;
    bit       erco;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit ln, int d, bit p, bit t, bit u, int eq, bit etc, bit erco);
    vec_t v;
    v.ln = ln; v.d = 4'(d); v.p = p; v.t = t; v.u = u;
    v.eq = eq; v.etc = etc; v.erco = erco;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int s = 0; s < 2; s++) begin
      if (CLR) begin
        mq[s] = 0; mtc[s] = 0;
      end else if (!LOAD_n) begin
        mq[s]  = (int'(D) < 10) ? int'(D) : 9;
        mtc[s] = 0;
      end else if (ENP && ENT) begin
        mtc[s] = (UP ? (mq[s] == 9) : (mq[s] == 0)) ? 1 : 0;
        if (s == 0) mq[s] = UP ? (mq[s] + 1) % 10 : (mq[s] + 9) % 10;
        else        mq[s] = UP ? ((mq[s] < 9) ? mq[s] + 1 : 9) : ((mq[s] > 0) ? mq[s] - 1 : 0);
      end else begin
        mtc[s] = 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int er[2];
    for (int s = 0; s < 2; s++)
      er[s] = (ENT && (UP ? (mq[s] == 9) : (mq[s] == 0))) ? 1 : 0;
    chk({tag, "_wrap_q"},   32'(q_w),   32'(mq[0]));
    chk({tag, "_wrap_tc"},  32'(tc_w),  32'(mtc[0]));
    chk({tag, "_wrap_rco"}, 32'(rco_w), 32'(er[0]));
    chk({tag, "_sat_q"},    32'(q_s),   32'(mq[1]));
    chk({tag, "_sat_tc"},   32'(tc_s),  32'(mtc[1]));
    chk({tag, "_sat_rco"},  32'(rco_s), 32'(er[1]));
  endtask

  task automatic step(input bit ln, input logic [3:0] d, input bit p, input bit t, input bit u,
                      input string tag);
    LOAD_n = ln; D = d; ENP = p; ENT = t; UP = u;
    @(posedge CLK);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Asserts and releases CLR strictly between clock edges.
  task automatic clr_pulse(input string tag);
    #2 CLR = 1'b1;
    #1;
    mq[0] = 0; mq[1] = 0; mtc[0] = 0; mtc[1] = 0;
    check_model(tag);
    #2 CLR = 1'b0;
  endtask

  initial begin
    CLR = 1'b1; D = '0; LOAD_n = 1'b1; ENP = 1'b1; ENT = 1'b1; UP = 1'b1;
    mq[0] = 0; mq[1] = 0; mtc[0] = 0; mtc[1] = 0;
    #12;
    check_model("reset");
    CLR = 1'b0;

    // Directed table, literal expectations for the wrap instance.
    for (int i = 1; i <= 9; i++) vecs.push_back(mk(1, 0, 1, 1, 1, i, 0, i == 9));
    vecs.push_back(mk(1, 0, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 9, 1, 0));
    for (int i = 8; i >= 0; i--) vecs.push_back(mk(1, 0, 1, 1, 0, i, 0, i == 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 9, 1, 0));
    vecs.push_back(mk(0, 12, 0, 1, 1, 9, 0, 1));
    vecs.push_back(mk(0, 3, 1, 1, 1, 3, 0, 0));
    vecs.push_back(mk(0, 9, 1, 1, 1, 9, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 9, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 1, 9, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].ln, vecs[i].d, vecs[i].p, vecs[i].t, vecs[i].u, "tbl");
      chk($sformatf("tbl%0d_q", i),   32'(q_w),   32'(vecs[i].eq));
      chk($sformatf("tbl%0d_tc", i),  32'(tc_w),  32'(vecs[i].etc));
      chk($sformatf("tbl%0d_rco", i), 32'(rco_w), 32'(vecs[i].erco));
    end

    // Saturate: load 7 then four up-counts.
    step(0, 4'd7, 1, 1, 1, "sat_ld");
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd0, 1, 1, 1, "sat_cnt");
      chk($sformatf("sat_lit%0d_q", i),  32'(q_s),  (i == 0) ? 32'd8 : 32'd9);
      chk($sformatf("sat_lit%0d_tc", i), 32'(tc_s), (i >= 2) ? 32'd1 : 32'd0);
    end

    // Async clear at Q=5, then after a terminal event so TC_PULSE is high.
    step(0, 4'd5, 0, 1, 1, "ld5");
    clr_pulse("clr_q5");
    step(0, 4'd9, 1, 1, 1, "ld9");
    step(1, 4'd0, 1, 1, 1, "wrap_before_clr");
    chk("tc_set_before_clr", 32'(tc_w), 32'd1);
    #2 CLR = 1'b1;
    #1;
    chk("clr_async_q",  32'(q_w),  32'd0);
    chk("clr_async_tc", 32'(tc_w), 32'd0);
    UP = 1'b0;
    #1;
    chk("clr_rco_down", 32'(rco_w), 32'd1);
    // CLR held across an edge with count enabled: reset wins.
    step(1, 4'd0, 1, 1, 1, "clr_edge");
    #2 CLR = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1, 4'd0, 1, 1, 1, "resume");
      chk($sformatf("resume%0d_q", i), 32'(q_w), 32'(i));
    end

    // Random stimulus against the reference model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        clr_pulse("rnd_clr");
      end else begin
        step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
             1'($urandom_range(0, 1)), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
